// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Brief    : Shared calculator constants: key codes, entry FSM states,
//             digit-shifter operations and ALU operation codes.
//  Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

  // Keypad codes above the digit range
  localparam logic [3:0] KEY_SIGN   = 4'd10;
  localparam logic [3:0] KEY_BACK   = 4'd11;
  localparam logic [3:0] KEY_CLEAR  = 4'd12;
  localparam logic [3:0] KEY_COMMIT = 4'd13;

  // Operand entry FSM encoding
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Digit shifter operations
  localparam logic [1:0] SH_KEEP = 2'd0;
  localparam logic [1:0] SH_ZERO = 2'd1;
  localparam logic [1:0] SH_INS  = 2'd2;
  localparam logic [1:0] SH_SHR  = 2'd3;

  // ALU operation codes shared with the arithmetic unit
  typedef enum logic [2:0] {
    SUM = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    EXP = 3'd4
  } alu_op_e;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/bcd_operand_entry_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_operand_entry_if
//  Brief    : Key-event input, live display and committed-operand handshake
//             bundle of the BCD operand entry block.
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_operand_entry_if #(
  parameter int DIGIT_NUM = 8
);
  localparam int CW = $clog2(DIGIT_NUM + 1);

  logic                   key_valid;
  logic [3:0]             key_code;
  logic                   key_ready;
  logic                   key_err;
  logic [4*DIGIT_NUM-1:0] entry_value;
  logic                   entry_sign;
  logic [CW-1:0]          entry_count;
  logic [4*DIGIT_NUM-1:0] out_operand;
  logic                   out_sign;
  logic                   out_valid;
  logic                   out_ready;

  // Key source / operand consumer side
  modport master (
    output key_valid, key_code, out_ready,
    input  key_ready, key_err, entry_value, entry_sign, entry_count,
           out_operand, out_sign, out_valid
  );

  // Operand entry block side
  modport slave (
    input  key_valid, key_code, out_ready,
    output key_ready, key_err, entry_value, entry_sign, entry_count,
           out_operand, out_sign, out_valid
  );
endinterface : bcd_operand_entry_if
`default_nettype wire

// File: rtl/bcd_operand_entry_digit_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_shifter
//  Brief    : DIGIT_NUM-nibble working register with load-zero,
//             shift-left-insert (new LS digit) and shift-right operations.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_shifter
  import calc_pkg::*;
#(
  parameter int DIGIT_NUM = 8
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic [1:0]             op,
  input  wire logic [3:0]             digit,
  output logic      [4*DIGIT_NUM-1:0] value
);
  localparam int W = 4 * DIGIT_NUM;

  logic [W-1:0] value_d;
  logic [W-1:0] value_q;

  // Next register contents for the requested operation
  always_comb begin
    value_d = value_q;
    case (op)
      SH_ZERO: value_d = '0;
      SH_INS:  value_d = {value_q[W-5:0], digit};
      SH_SHR:  value_d = {4'h0, value_q[W-1:4]};
      default: value_d = value_q;
    endcase
  end

  // Nibble register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule : bcd_digit_shifter
`default_nettype wire

// File: rtl/bcd_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_operand_entry
//  Brief    : Builds a signed-magnitude BCD operand from key events and hands
//             it to the ALU staging over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_operand_entry
  import calc_pkg::*;
#(
  parameter int DIGIT_NUM = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  bcd_operand_entry_if.slave bus
);
  localparam int W  = 4 * DIGIT_NUM;
  localparam int CW = $clog2(DIGIT_NUM + 1);
  localparam logic [CW-1:0] C_COUNT_FULL = CW'(DIGIT_NUM);
  localparam logic [CW-1:0] C_COUNT_ONE  = CW'(1);

  logic [1:0]    state_d,       state_q;
  logic [CW-1:0] count_d,       count_q;
  logic          sign_d,        sign_q;
  logic [W-1:0]  out_operand_d, out_operand_q;
  logic          out_sign_d,    out_sign_q;
  logic          out_valid_d,   out_valid_q;
  logic          key_err_d,     key_err_q;

  logic [1:0]    sh_op;
  logic [W-1:0]  value;
  logic          key_accept;

  bcd_digit_shifter #(.DIGIT_NUM(DIGIT_NUM)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (sh_op),
    .digit (bus.key_code),
    .value (value)
  );

  // No key is taken while a committed operand waits for the ALU
  assign key_accept = bus.key_valid & ~out_valid_q;

  // Key decode, entry FSM and output handshake
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    sign_d        = sign_q;
    out_operand_d = out_operand_q;
    out_sign_d    = out_sign_q;
    out_valid_d   = out_valid_q;
    key_err_d     = 1'b0;
    sh_op         = SH_KEEP;

    if (out_valid_q) begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ST_EMPTY;
      end
    end else if (key_accept) begin
      if (bus.key_code < KEY_SIGN) begin
        if (count_q == C_COUNT_FULL) begin
          key_err_d = 1'b1;
        end else if (!((count_q == '0) && (bus.key_code == 4'd0))) begin
          // Leading zeros are swallowed so count tracks significant digits
          sh_op   = SH_INS;
          count_d = count_q + C_COUNT_ONE;
          state_d = (count_d == C_COUNT_FULL) ? ST_FULL : ST_ENTRY;
        end
      end else begin
        case (bus.key_code)
          KEY_SIGN: sign_d = ~sign_q;
          KEY_BACK: begin
            if (count_q == '0) begin
              key_err_d = 1'b1;
            end else begin
              sh_op   = SH_SHR;
              count_d = count_q - C_COUNT_ONE;
              if (count_q == C_COUNT_ONE) begin
                sign_d  = 1'b0;
                state_d = ST_EMPTY;
              end else begin
                state_d = ST_ENTRY;
              end
            end
          end
          KEY_CLEAR: begin
            sh_op   = SH_ZERO;
            count_d = '0;
            sign_d  = 1'b0;
            state_d = ST_EMPTY;
          end
          KEY_COMMIT: begin
            // Zero magnitude is always emitted positive
            out_operand_d = value;
            out_sign_d    = sign_q & (count_q != '0);
            out_valid_d   = 1'b1;
            sh_op         = SH_ZERO;
            count_d       = '0;
            sign_d        = 1'b0;
            state_d       = ST_HOLD;
          end
          default: key_err_d = 1'b1;
        endcase
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      count_q       <= '0;
      sign_q        <= 1'b0;
      out_operand_q <= '0;
      out_sign_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      key_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sign_q        <= sign_d;
      out_operand_q <= out_operand_d;
      out_sign_q    <= out_sign_d;
      out_valid_q   <= out_valid_d;
      key_err_q     <= key_err_d;
    end
  end

  assign bus.key_ready   = ~out_valid_q;
  assign bus.key_err     = key_err_q;
  assign bus.entry_value = value;
  assign bus.entry_sign  = sign_q;
  assign bus.entry_count = count_q;
  assign bus.out_operand = out_operand_q;
  assign bus.out_sign    = out_sign_q;
  assign bus.out_valid   = out_valid_q;

endmodule : bcd_operand_entry
`default_nettype wire

// File: tb/tb_bcd_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_operand_entry
//  Brief    : Directed self-checking bench for bcd_operand_entry.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_operand_entry;
  import calc_pkg::*;

  localparam int DIGIT_NUM = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bcd_operand_entry_if #(.DIGIT_NUM(DIGIT_NUM)) bus ();

  bcd_operand_entry #(.DIGIT_NUM(DIGIT_NUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one key for one cycle; returns at the negedge after it is taken
  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_key_ready",   32'(bus.key_ready),   32'd1);
    check("rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("rst_entry_value", 32'(bus.entry_value), 32'd0);
    check("rst_entry_count", 32'(bus.entry_count), 32'd0);
    check("rst_key_err",     32'(bus.key_err),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: leading zeros, digits, commit held off by out_ready
    press(4'd0);
    press(4'd0);
    check("t1_lead_zero_count", 32'(bus.entry_count), 32'd0);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check("t1_value", 32'(bus.entry_value), 32'h0000_0123);
    check("t1_count", 32'(bus.entry_count), 32'd3);
    press(KEY_COMMIT);
    check("t1_out_valid",   32'(bus.out_valid),   32'd1);
    check("t1_out_operand", 32'(bus.out_operand), 32'h0000_0123);
    check("t1_out_sign",    32'(bus.out_sign),    32'd0);
    check("t1_key_ready",   32'(bus.key_ready),   32'd0);
    check("t1_work_cleared", 32'(bus.entry_value), 32'd0);
    @(negedge clk);
    check("t1_hold_valid",  32'(bus.out_valid),   32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t1_hs_valid",    32'(bus.out_valid),   32'd0);
    check("t1_hs_ready",    32'(bus.key_ready),   32'd1);

    // 2: overflow digit rejected when full
    for (int d = 1; d <= 8; d++) press(4'(d));
    check("t2_full_value", 32'(bus.entry_value), 32'h1234_5678);
    check("t2_full_count", 32'(bus.entry_count), 32'd8);
    press(4'd9);
    check("t2_err_pulse",  32'(bus.key_err),     32'd1);
    check("t2_value_kept", 32'(bus.entry_value), 32'h1234_5678);
    check("t2_count_kept", 32'(bus.entry_count), 32'd8);
    @(negedge clk);
    check("t2_err_one_cycle", 32'(bus.key_err),  32'd0);
    press(KEY_CLEAR);
    check("t2_clear_value", 32'(bus.entry_value), 32'd0);
    check("t2_clear_count", 32'(bus.entry_count), 32'd0);

    // 3: backspace to empty clears sign, commit yields +0
    press(4'd4);
    press(4'd5);
    check("t3_value45", 32'(bus.entry_value), 32'h45);
    press(KEY_SIGN);
    check("t3_sign_set", 32'(bus.entry_sign), 32'd1);
    press(KEY_BACK);
    check("t3_value4",   32'(bus.entry_value), 32'h4);
    check("t3_sign_kept", 32'(bus.entry_sign), 32'd1);
    press(KEY_BACK);
    check("t3_value0",   32'(bus.entry_value), 32'h0);
    check("t3_sign_clr", 32'(bus.entry_sign), 32'd0);
    press(KEY_BACK);
    check("t3_back_empty_err", 32'(bus.key_err), 32'd1);
    press(KEY_COMMIT);
    check("t3_out_valid",   32'(bus.out_valid),   32'd1);
    check("t3_out_operand", 32'(bus.out_operand), 32'd0);
    check("t3_out_sign",    32'(bus.out_sign),    32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // 4: negative operand, single-cycle valid
    press(KEY_SIGN);
    press(4'd7);
    press(KEY_COMMIT);
    check("t4_out_valid",   32'(bus.out_valid),   32'd1);
    check("t4_out_operand", 32'(bus.out_operand), 32'h7);
    check("t4_out_sign",    32'(bus.out_sign),    32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_valid_one_cycle", 32'(bus.out_valid), 32'd0);

    // 5: key held during HOLD is only taken after the handshake
    press(4'd1);
    press(KEY_COMMIT);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_hold_ready", 32'(bus.key_ready),   32'd0);
      check("t5_hold_value", 32'(bus.entry_value), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t5_after_hs_ready", 32'(bus.key_ready),   32'd1);
    check("t5_after_hs_value", 32'(bus.entry_value), 32'd0);
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("t5_consumed_value", 32'(bus.entry_value), 32'h3);
    check("t5_consumed_count", 32'(bus.entry_count), 32'd1);

    // 6: invalid code, then asynchronous reset in HOLD
    press(4'd15);
    check("t6_bad_code_err",   32'(bus.key_err),     32'd1);
    check("t6_bad_code_value", 32'(bus.entry_value), 32'h3);
    check("t6_bad_code_count", 32'(bus.entry_count), 32'd1);
    press(KEY_SIGN);
    press(KEY_COMMIT);
    check("t6_hold_valid", 32'(bus.out_valid),   32'd1);
    check("t6_hold_sign",  32'(bus.out_sign),    32'd1);
    check("t6_hold_oper",  32'(bus.out_operand), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",   32'(bus.out_valid),   32'd0);
    check("t6_rst_operand", 32'(bus.out_operand), 32'd0);
    check("t6_rst_sign",    32'(bus.out_sign),    32'd0);
    check("t6_rst_value",   32'(bus.entry_value), 32'd0);
    check("t6_rst_ready",   32'(bus.key_ready),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bcd_operand_entry
`default_nettype wire

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
Builds one signed-magnitude BCD operand from keypad key events. Digits are shifted in from the right, as on a calculator. The block supports sign toggle, backspace, clear and commit. On commit it hands the finished operand to the ALU operand staging over a valid/ready handshake. The output format matches the ALU operand input: 4*DIGIT_NUM-bit packed BCD, LS digit in bits [3:0], plus a separate sign bit (1 = negative).

Parameters:
DIGIT_NUM, 8, number of BCD digits in the operand

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  key event present
key_code  in  4  0-9 digit; 10 SIGN; 11 BACK; 12 CLEAR; 13 COMMIT; 14-15 invalid
key_ready  out  1  block can accept a key this cycle
entry_value  out  4*DIGIT_NUM  live working magnitude, for the display
entry_sign  out  1  live working sign
entry_count  out  $clog2(DIGIT_NUM+1)  significant digits entered
out_operand  out  4*DIGIT_NUM  committed magnitude
out_sign  out  1  committed sign
out_valid  out  1  committed operand available
out_ready  in  1  ALU staging accepts the operand
key_err  out  1  one-cycle pulse when a key is rejected

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs are 0, except key_ready=1.
  - State is EMPTY.
  - Reset in HOLD drops out_valid immediately; the pending operand is discarded.
- States:
  - EMPTY: count=0.
  - ENTRY: 0<count<DIGIT_NUM.
  - FULL: count=DIGIT_NUM.
  - HOLD: a committed operand is waiting for out_ready.
- key_ready = ~out_valid. A key is consumed when key_valid & key_ready. Its effect appears on outputs the next cycle (latency 1).
- Digit d:
  - EMPTY with d=0: value stays 0, count stays 0 (no leading zeros).
  - EMPTY with d!=0, or ENTRY: value <= {value[4*DIGIT_NUM-5:0], d}; count+1. EMPTY goes to ENTRY; ENTRY goes to FULL when count reaches DIGIT_NUM.
  - FULL: no change; key_err pulses.
- SIGN: entry_sign toggles in any non-HOLD state. A toggle in EMPTY is allowed.
- BACK:
  - EMPTY: key_err pulses, no change.
  - Otherwise: value <= value>>4 with a zero nibble shifted in at the top; count-1.
  - When count reaches 0, entry_sign is cleared and the state goes to EMPTY. FULL goes to ENTRY.
- CLEAR: value, sign and count go to 0; state goes to EMPTY. This is legal in EMPTY/ENTRY/FULL.
- COMMIT:
  - out_operand <= value.
  - out_sign <= entry_sign & (count!=0), so negative zero is never emitted.
  - out_valid <= 1; state goes to HOLD.
  - The working register (value, sign, count) is cleared in the same edge.
  - Committing from EMPTY is legal and yields +0.
- HOLD:
  - out_operand and out_sign stay stable while out_valid=1.
  - Key events are not consumed (key_ready=0). The key source must hold key_valid/key_code.
  - Handshake completes on the edge where out_valid & out_ready. Next cycle: out_valid=0, key_ready=1, state EMPTY.
- out_ready while out_valid=0 is ignored.
- Codes 14-15: key_err pulses; no state change.
- key_err is registered; high exactly one cycle after the rejected key is consumed.
- Only digit nibbles 0-9 ever enter value; the magnitude is always valid BCD.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants: KEY_SIGN=10, KEY_BACK=11, KEY_CLEAR=12, KEY_COMMIT=13;
  - the state encoding (EMPTY, ENTRY, FULL, HOLD);
  - the operation codes (SUM=0, SUB=1, MUL=2, DIV=3, EXP=4) shared with the ALU.
- One sub-module, bcd_digit_shifter, is natural. It is the DIGIT_NUM-nibble register with load-zero, shift-left-insert and shift-right operations.
- The FSM, count, sign and output handshake stay in the top module.

Test Plan:
1. Reset, then keys 0,0,1,2,3,COMMIT, with out_ready held 0 → entry_value=0x00000123 and entry_count=3 before commit. out_valid=1, out_operand=0x00000123, out_sign=0. key_ready=0 until out_ready=1; after the handshake out_valid=0 and state EMPTY.
2. Keys 1..8 then 9 → 9th key pulses key_err; entry_value stays 0x12345678, entry_count=8.
3. Keys 4,5,SIGN,BACK,BACK,COMMIT → intermediate entry_value 0x45, then 0x4, then 0. Sign is cleared on reaching count 0. Committed result is +0 (out_sign=0).
4. Keys SIGN,7,COMMIT with out_ready=1 the cycle after out_valid rises → out_operand=0x7, out_sign=1. out_valid is high exactly one cycle.
5. In HOLD, present key_valid with code 3 for 4 cycles, then raise out_ready → key not consumed in HOLD. It is consumed the cycle after the handshake, giving entry_value=0x3.
6. Assert rst_n=0 mid-HOLD → out_valid, out_operand, entry_value and out_sign drop to 0 without a clock edge. Also check code 15 produces a key_err pulse and no change.
